// File: rtl/grf_write_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | grf_write_tracker                                                          |
// | Tracks in-flight register writes through E/M/W, forwards to D, and drives  |
// | the GRF write port from W.                                                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module grf_write_tracker #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_wa,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic [DATA_W-1:0] d_wd,
  input  logic [ADDR_W-1:0] d_ra1,
  input  logic [ADDR_W-1:0] d_ra2,
  input  logic [DATA_W-1:0] e_res,
  input  logic [DATA_W-1:0] m_res,
  output logic              stall,
  output logic              fwd1_sel,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_sel,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              grf_we,
  output logic [ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0] grf_wd
);

  localparam logic [TNEW_W-1:0] c_tnew_max = TNEW_W'(2);
  localparam logic [TNEW_W-1:0] c_tnew_one = TNEW_W'(1);

  logic              r_e_valid, r_m_valid, r_w_valid;
  logic [ADDR_W-1:0] r_e_wa, r_m_wa, r_w_wa;
  logic [TNEW_W-1:0] r_e_tnew, r_m_tnew;
  logic [DATA_W-1:0] r_e_data, r_m_data, r_w_data;

  logic [TNEW_W-1:0] w_d_tnew;
  logic              w_d_valid;
  logic [ADDR_W-1:0] w_ra    [2];
  logic [1:0]        w_sel;
  logic [1:0]        w_req;
  logic [DATA_W-1:0] w_fdata [2];
  logic              w_stall;

  // Tnew of 3 is not a legal encoding; saturate it to the load case.
  assign w_d_tnew  = (d_tnew > c_tnew_max) ? c_tnew_max : d_tnew;
  assign w_d_valid = d_valid && (d_wa != '0);

  always_ff @(posedge clk) begin
    if (RESET || w_stall) begin
      r_e_valid <= 1'b0;
      r_e_wa    <= '0;
      r_e_tnew  <= '0;
      r_e_data  <= '0;
    end else begin
      r_e_valid <= w_d_valid;
      r_e_wa    <= d_wa;
      r_e_tnew  <= w_d_tnew;
      r_e_data  <= d_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_m_valid <= 1'b0;
      r_m_wa    <= '0;
      r_m_tnew  <= '0;
      r_m_data  <= '0;
      r_w_valid <= 1'b0;
      r_w_wa    <= '0;
      r_w_data  <= '0;
    end else begin
      r_m_valid <= r_e_valid;
      r_m_wa    <= r_e_wa;
      r_m_tnew  <= (r_e_tnew == '0) ? '0 : (r_e_tnew - c_tnew_one);
      r_m_data  <= (r_e_tnew == '0) ? r_e_data : e_res;
      r_w_valid <= r_m_valid;
      r_w_wa    <= r_m_wa;
      r_w_data  <= (r_m_tnew == '0) ? r_m_data : m_res;
    end
  end

  assign w_ra[0] = d_ra1;
  assign w_ra[1] = d_ra2;

  // Youngest producer (E) shadows older ones (M); W is bypassed inside the GRF.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_sel[p]   = 1'b0;
      w_req[p]   = 1'b0;
      w_fdata[p] = '0;
      if (w_ra[p] != '0) begin
        if (r_e_valid && (r_e_wa == w_ra[p])) begin
          if (r_e_tnew == '0) begin
            w_sel[p]   = 1'b1;
            w_fdata[p] = r_e_data;
          end else begin
            w_req[p] = 1'b1;
          end
        end else if (r_m_valid && (r_m_wa == w_ra[p])) begin
          if (r_m_tnew == '0) begin
            w_sel[p]   = 1'b1;
            w_fdata[p] = r_m_data;
          end else begin
            w_req[p] = 1'b1;
          end
        end
      end
    end
  end

  assign w_stall   = |w_req;
  assign stall     = w_stall;
  assign fwd1_sel  = w_sel[0];
  assign fwd1_data = w_fdata[0];
  assign fwd2_sel  = w_sel[1];
  assign fwd2_data = w_fdata[1];

  assign grf_we = r_w_valid;
  assign grf_a3 = r_w_wa;
  assign grf_wd = r_w_data;

endmodule
`default_nettype wire

// File: tb/tb_grf_write_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_grf_write_tracker                                                       |
// | Directed scenarios plus randomized traffic against a write-history model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_grf_write_tracker;

  logic        clk = 1'b0;
  logic        RESET;
  logic        d_valid;
  logic [4:0]  d_wa;
  logic [1:0]  d_tnew;
  logic [31:0] d_wd;
  logic [4:0]  d_ra1, d_ra2;
  logic [31:0] e_res, m_res;
  logic        stall, fwd1_sel, fwd2_sel, grf_we;
  logic [31:0] fwd1_data, fwd2_data, grf_wd;
  logic [4:0]  grf_a3;

  int total = 0;
  int bad   = 0;

  grf_write_tracker #(.DATA_W(32), .ADDR_W(5), .TNEW_W(2)) dut (
    .clk(clk), .RESET(RESET), .d_valid(d_valid), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_wd(d_wd), .d_ra1(d_ra1), .d_ra2(d_ra2), .e_res(e_res), .m_res(m_res),
    .stall(stall), .fwd1_sel(fwd1_sel), .fwd1_data(fwd1_data),
    .fwd2_sel(fwd2_sel), .fwd2_data(fwd2_data),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of the last three issue slots, youngest first (age 1..3).
  // An entry's result exists once its age exceeds its Tnew.
  typedef struct {
    bit          v;
    logic [4:0]  wa;
    int          tn;
    logic [31:0] val;
  } ent_t;

  ent_t h [3];
  bit   live = 1'b0;

  function automatic void exp_port(input logic [4:0] ra, output bit sel,
                                   output logic [31:0] data, output bit req);
    bit found;
    sel = 1'b0; data = '0; req = 1'b0; found = 1'b0;
    if (ra != 5'd0) begin
      for (int a = 0; a < 2; a++) begin
        if (!found && h[a].v && h[a].wa == ra) begin
          found = 1'b1;
          if (a + 1 > h[a].tn) begin
            sel  = 1'b1;
            data = h[a].val;
          end else begin
            req = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic bit exp_stall();
    bit s1, s2, r1, r2;
    logic [31:0] x1, x2;
    exp_port(d_ra1, s1, x1, r1);
    exp_port(d_ra2, s2, x2, r2);
    return r1 | r2;
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 3; i++) h[i] = '{1'b0, 5'd0, 0, 32'd0};
      live = 1'b1;
    end else if (live) begin
      bit st;
      st = exp_stall();
      if (h[0].tn == 1) h[0].val = e_res;
      if (h[1].tn == 2) h[1].val = m_res;
      h[2] = h[1];
      h[1] = h[0];
      h[0].v   = d_valid && (d_wa != 5'd0) && !st;
      h[0].wa  = d_wa;
      h[0].tn  = (d_tnew > 2'd2) ? 2 : int'(d_tnew);
      h[0].val = d_wd;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      bit s1, s2, r1, r2;
      logic [31:0] x1, x2;
      exp_port(d_ra1, s1, x1, r1);
      exp_port(d_ra2, s2, x2, r2);
      chk("m_stall", {31'd0, stall}, {31'd0, r1 | r2});
      chk("m_we", {31'd0, grf_we}, {31'd0, h[2].v});
      if (h[2].v) begin
        chk("m_a3", {27'd0, grf_a3}, {27'd0, h[2].wa});
        chk("m_wd", grf_wd, h[2].val);
      end
      if (!(r1 | r2)) begin
        chk("m_sel1", {31'd0, fwd1_sel}, {31'd0, s1});
        chk("m_fd1", fwd1_data, x1);
        chk("m_sel2", {31'd0, fwd2_sel}, {31'd0, s2});
        chk("m_fd2", fwd2_data, x2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 1'b0; d_wa = '0; d_tnew = '0; d_wd = '0;
    d_ra1 = '0; d_ra2 = '0; e_res = '0; m_res = '0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [1:0] tn, input logic [31:0] wd);
    d_valid = 1'b1; d_wa = wa; d_tnew = tn; d_wd = wd;
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    tick(); tick();
    RESET = 1'b0;
    @(negedge clk);
    chk("rst_we", {31'd0, grf_we}, 32'd0);
    chk("rst_a3", {27'd0, grf_a3}, 32'd0);
    chk("rst_wd", grf_wd, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_sel1", {31'd0, fwd1_sel}, 32'd0);
    chk("rst_fd1", fwd1_data, 32'd0);
    tick();
    // ALU chain
    idle(); issue(5'd5, 2'd1, 32'hAAAA); tick();
    idle(); d_ra1 = 5'd5; e_res = 32'h1234;
    @(negedge clk); chk("alu_stall", {31'd0, stall}, 32'd1); tick();
    idle(); d_ra1 = 5'd5; e_res = 32'h9999;
    @(negedge clk);
    chk("alu_nostall", {31'd0, stall}, 32'd0);
    chk("alu_sel1", {31'd0, fwd1_sel}, 32'd1);
    chk("alu_fd1", fwd1_data, 32'h1234);
    tick();
    // Load-use; W of the ALU write is visible this cycle
    idle(); issue(5'd8, 2'd2, 32'h0);
    @(negedge clk);
    chk("alu_we", {31'd0, grf_we}, 32'd1);
    chk("alu_a3", {27'd0, grf_a3}, 32'd5);
    chk("alu_wd", grf_wd, 32'h1234);
    tick();
    idle(); d_ra2 = 5'd8;
    @(negedge clk); chk("lu_stall1", {31'd0, stall}, 32'd1); tick();
    idle(); d_ra2 = 5'd8; m_res = 32'hDEADBEEF;
    @(negedge clk); chk("lu_stall2", {31'd0, stall}, 32'd1); tick();
    idle(); d_ra2 = 5'd8;
    @(negedge clk);
    chk("lu_nostall", {31'd0, stall}, 32'd0);
    chk("lu_sel2", {31'd0, fwd2_sel}, 32'd0);
    chk("lu_we", {31'd0, grf_we}, 32'd1);
    chk("lu_a3", {27'd0, grf_a3}, 32'd8);
    chk("lu_wd", grf_wd, 32'hDEADBEEF);
    tick();
    // Link forward
    idle(); issue(5'd31, 2'd0, 32'h3008); tick();
    idle(); d_ra1 = 5'd31;
    @(negedge clk);
    chk("lk_stall", {31'd0, stall}, 32'd0);
    chk("lk_sel1", {31'd0, fwd1_sel}, 32'd1);
    chk("lk_fd1", fwd1_data, 32'h3008);
    tick();
    // Priority and register zero
    idle(); issue(5'd3, 2'd0, 32'h22); tick();
    idle(); issue(5'd3, 2'd0, 32'h11); tick();
    idle(); d_ra1 = 5'd3; issue(5'd0, 2'd0, 32'h55);
    @(negedge clk);
    chk("pr_sel1", {31'd0, fwd1_sel}, 32'd1);
    chk("pr_fd1", fwd1_data, 32'h11);
    tick();
    idle();
    @(negedge clk);
    chk("z_stall", {31'd0, stall}, 32'd0);
    chk("z_sel2", {31'd0, fwd2_sel}, 32'd0);
    chk("pr_wd_old", grf_wd, 32'h22);
    tick();
    idle();
    @(negedge clk); chk("pr_wd_new", grf_wd, 32'h11); tick();
    // Dual port; W holds the register-0 write here
    idle(); issue(5'd7, 2'd0, 32'h77);
    @(negedge clk); chk("z_we", {31'd0, grf_we}, 32'd0); tick();
    idle(); issue(5'd4, 2'd1, 32'h0); tick();
    idle(); issue(5'd9, 2'd0, 32'h99); d_ra1 = 5'd7; d_ra2 = 5'd4; e_res = 32'h44;
    @(negedge clk);
    chk("dp_stall", {31'd0, stall}, 32'd1);
    chk("dp_sel1", {31'd0, fwd1_sel}, 32'd1);
    chk("dp_fd1", fwd1_data, 32'h77);
    tick();
    idle(); tick();
    idle();
    @(negedge clk);
    chk("dp_we", {31'd0, grf_we}, 32'd1);
    chk("dp_a3", {27'd0, grf_a3}, 32'd4);
    chk("dp_wd", grf_wd, 32'h44);
    tick();
    // Reset mid-operation
    idle(); issue(5'd10, 2'd0, 32'hA);
    @(negedge clk); chk("dp_bubble", {31'd0, grf_we}, 32'd0); tick();
    idle(); issue(5'd11, 2'd1, 32'h0); e_res = 32'hB; tick();
    idle(); issue(5'd12, 2'd0, 32'hC); RESET = 1'b1; tick();
    RESET = 1'b0; idle(); d_ra1 = 5'd10;
    @(negedge clk);
    chk("mr_we", {31'd0, grf_we}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    chk("mr_sel1", {31'd0, fwd1_sel}, 32'd0);
    tick();
    idle();
    @(negedge clk); chk("mr_we2", {31'd0, grf_we}, 32'd0); tick();
    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      RESET   = ($urandom_range(0, 99) == 0);
      d_valid = $urandom_range(0, 3) != 0;
      d_wa    = 5'($urandom_range(0, 7));
      d_tnew  = 2'($urandom_range(0, 3));
      d_wd    = $urandom;
      d_ra1   = 5'($urandom_range(0, 7));
      d_ra2   = 5'($urandom_range(0, 7));
      e_res   = $urandom;
      m_res   = $urandom;
      tick();
    end
    RESET = 1'b0;
    idle();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
